// File: rtl/posit_add_arbiter_es3.sv
// Round-robin arbiter sharing one ES=3 posit adder pipeline among N_REQ requesters,
// with per-requester result slots and a tag pipe that routes each sum back to its owner.

package posit_es3_pkg;
    localparam int POSIT_ES3_FRAC_W             = 10;
    localparam int POSIT_ES3_SCALE_W            = 9;
    localparam int POSIT_ES3_SUM_FRAC_W         = 14;
    // {sign, zero, inf, scale, fraction-without-hidden-bit}
    localparam int POSIT_SERIALIZED_WIDTH_ES3     = 3 + POSIT_ES3_SCALE_W + POSIT_ES3_FRAC_W;
    // {sign, zero, inf, scale, hidden + fraction + guard bits + sticky}
    localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 3 + POSIT_ES3_SCALE_W + POSIT_ES3_SUM_FRAC_W;
endpackage

// Raw (unrounded) serialized posit adder, fixed 4-cycle start-to-done latency, no reset.
module positadd_4_raw_es3
    import posit_es3_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      start,
    input  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]     in1,
    input  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]     in2,
    output logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] result,
    output logic                                      done
);
    localparam int FW   = POSIT_ES3_FRAC_W;
    localparam int SW   = POSIT_ES3_SCALE_W;
    localparam int MW   = POSIT_ES3_SUM_FRAC_W;
    localparam int SH_W = $clog2(MW + 1);

    logic          a_sign, a_zero, a_inf, b_sign, b_zero, b_inf;
    logic [SW-1:0] a_scale, b_scale;
    logic [FW-1:0] a_frac, b_frac;
    logic [MW-1:0] a_mant, b_mant;
    logic          a_is_big;
    logic [SW:0]   scale_diff;
    logic [SH_W-1:0] shift_amt;

    assign {a_sign, a_zero, a_inf, a_scale, a_frac} = in1;
    assign {b_sign, b_zero, b_inf, b_scale, b_frac} = in2;

    // A zero operand contributes a zero mantissa, so the generic add path returns the other one.
    assign a_mant = a_zero ? '0 : {1'b1, a_frac, {(MW-FW-1){1'b0}}};
    assign b_mant = b_zero ? '0 : {1'b1, b_frac, {(MW-FW-1){1'b0}}};

    always_comb begin
        a_is_big = 1'b0;
        if (a_zero)
            a_is_big = 1'b0;
        else if (b_zero)
            a_is_big = 1'b1;
        else if (a_scale != b_scale)
            a_is_big = $signed(a_scale) > $signed(b_scale);
        else
            a_is_big = a_frac >= b_frac;

        scale_diff = a_is_big ? ({a_scale[SW-1], a_scale} - {b_scale[SW-1], b_scale})
                              : ({b_scale[SW-1], b_scale} - {a_scale[SW-1], a_scale});
        if (scale_diff[SW] || scale_diff > (SW+1)'(MW))
            shift_amt = SH_W'(MW);
        else
            shift_amt = scale_diff[SH_W-1:0];
    end

    // Stage 1: operands ordered by magnitude
    logic [MW-1:0]   s1_big_m_reg, s1_small_m_reg;
    logic [SH_W-1:0] s1_shift_reg;
    logic [SW-1:0]   s1_scale_reg;
    logic            s1_sign_reg, s1_sub_reg, s1_inf_reg;

    always_ff @(posedge clk) begin
        s1_big_m_reg   <= a_is_big ? a_mant : b_mant;
        s1_small_m_reg <= a_is_big ? b_mant : a_mant;
        s1_shift_reg   <= shift_amt;
        s1_scale_reg   <= a_is_big ? a_scale : b_scale;
        s1_sign_reg    <= a_is_big ? a_sign : b_sign;
        s1_sub_reg     <= a_sign ^ b_sign;
        s1_inf_reg     <= a_inf | b_inf;
    end

    // Stage 2: align the smaller mantissa, folding shifted-out bits into a sticky LSB
    logic [MW-1:0] align_mask, aligned_m;

    always_comb begin
        align_mask = ~({MW{1'b1}} << s1_shift_reg);
        aligned_m  = (s1_small_m_reg >> s1_shift_reg)
                   | {{(MW-1){1'b0}}, |(s1_small_m_reg & align_mask)};
    end

    logic [MW-1:0] s2_big_m_reg, s2_aligned_reg;
    logic [SW-1:0] s2_scale_reg;
    logic          s2_sign_reg, s2_sub_reg, s2_inf_reg;

    always_ff @(posedge clk) begin
        s2_big_m_reg   <= s1_big_m_reg;
        s2_aligned_reg <= aligned_m;
        s2_scale_reg   <= s1_scale_reg;
        s2_sign_reg    <= s1_sign_reg;
        s2_sub_reg     <= s1_sub_reg;
        s2_inf_reg     <= s1_inf_reg;
    end

    // Stage 3: magnitude add/subtract; big >= aligned so the difference never goes negative
    logic [MW:0]   s3_sum_reg;
    logic [SW-1:0] s3_scale_reg;
    logic          s3_sign_reg, s3_inf_reg;

    always_ff @(posedge clk) begin
        s3_sum_reg   <= s2_sub_reg ? ({1'b0, s2_big_m_reg} - {1'b0, s2_aligned_reg})
                                   : ({1'b0, s2_big_m_reg} + {1'b0, s2_aligned_reg});
        s3_scale_reg <= s2_scale_reg;
        s3_sign_reg  <= s2_sign_reg;
        s3_inf_reg   <= s2_inf_reg;
    end

    // Stage 4: normalise so the hidden bit sits at the fraction MSB
    logic [SH_W-1:0] lzc;
    logic            lz_found;
    logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] norm_next;

    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int k = MW - 1; k >= 0; k--) begin
            if (!lz_found && s3_sum_reg[k]) begin
                lzc      = SH_W'(MW - 1 - k);
                lz_found = 1'b1;
            end
        end

        if (s3_inf_reg)
            norm_next = {3'b001, {SW{1'b0}}, {MW{1'b0}}};
        else if (s3_sum_reg == '0)
            norm_next = {3'b010, {SW{1'b0}}, {MW{1'b0}}};
        else if (s3_sum_reg[MW])
            norm_next = {s3_sign_reg, 2'b00, s3_scale_reg + SW'(1),
                         s3_sum_reg[MW:2], s3_sum_reg[1] | s3_sum_reg[0]};
        else
            norm_next = {s3_sign_reg, 2'b00, s3_scale_reg - SW'(lzc),
                         s3_sum_reg[MW-1:0] << lzc};
    end

    logic [3:0] done_pipe_reg;

    always_ff @(posedge clk) begin
        result        <= norm_next;
        done_pipe_reg <= {done_pipe_reg[2:0], start};
    end

    assign done = done_pipe_reg[3];
endmodule

module posit_add_arbiter_es3
    import posit_es3_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 4
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [N_REQ-1:0]                                req_valid,
    output logic [N_REQ-1:0]                                req_ready,
    input  logic [N_REQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in1,
    input  logic [N_REQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in2,
    output logic [N_REQ-1:0]                                rsp_valid,
    input  logic [N_REQ-1:0]                                rsp_ready,
    output logic [N_REQ*POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] rsp_result,
    output logic                                            idle,
    output logic                                            err
);
    localparam int W     = POSIT_SERIALIZED_WIDTH_ES3;
    localparam int WS    = POSIT_SERIALIZED_WIDTH_SUM_ES3;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LAT + 1);

    logic [N_REQ-1:0] busy_reg;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic [WS-1:0]    slot_reg [N_REQ];
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [CNT_W-1:0] blank_cnt_reg;
    logic             err_reg;
    logic [LAT-1:0]   tag_valid_reg;
    logic [IDX_W-1:0] tag_idx_reg [LAT];

    logic             blanking;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] rsp_hs;
    logic [N_REQ-1:0] grant_vec;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;

    logic [W-1:0]     add_in1, add_in2;
    logic [WS-1:0]    add_result;
    logic             add_done;
    logic             tag_out_valid;
    logic [IDX_W-1:0] tag_out_idx;
    logic             retire;
    logic             mismatch;

    assign blanking = (blank_cnt_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign eligible[gi] = req_valid[gi] & ~busy_reg[gi] & ~blanking;
            assign rsp_hs[gi]   = rsp_valid_reg[gi] & rsp_ready[gi];
            assign rsp_result[gi*WS +: WS] = slot_reg[gi];
        end
    endgenerate

    // First eligible requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (grant_any)
            grant_vec[grant_idx] = 1'b1;
    end

    assign req_ready = grant_vec;
    assign add_in1   = req_in1[grant_idx*W +: W];
    assign add_in2   = req_in2[grant_idx*W +: W];

    positadd_4_raw_es3 u_add (
        .clk    (clk),
        .start  (grant_any),
        .in1    (add_in1),
        .in2    (add_in2),
        .result (add_result),
        .done   (add_done)
    );

    assign tag_out_valid = tag_valid_reg[LAT-1];
    assign tag_out_idx   = tag_idx_reg[LAT-1];
    // The adder is unreset, so its done line is only trusted once blanking has drained it
    assign retire        = ~blanking & add_done & tag_out_valid;
    assign mismatch      = ~blanking & (add_done != tag_out_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            for (int k = 0; k < LAT; k++)
                tag_idx_reg[k] <= '0;
        end else begin
            tag_valid_reg  <= {tag_valid_reg[LAT-2:0], grant_any};
            tag_idx_reg[0] <= grant_idx;
            for (int k = 1; k < LAT; k++)
                tag_idx_reg[k] <= tag_idx_reg[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            blank_cnt_reg <= CNT_W'(LAT);
            err_reg       <= 1'b0;
        end else begin
            if (blanking)
                blank_cnt_reg <= blank_cnt_reg - CNT_W'(1);
            if (grant_any)
                rr_ptr_reg <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            if (mismatch)
                err_reg <= 1'b1;
        end
    end

    // busy guarantees a retire and a consume never target the same slot in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= '0;
            rsp_valid_reg <= '0;
            for (int k = 0; k < N_REQ; k++)
                slot_reg[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_vec[k])
                    busy_reg[k] <= 1'b1;
                else if (rsp_hs[k])
                    busy_reg[k] <= 1'b0;

                if (retire && tag_out_idx == IDX_W'(k)) begin
                    rsp_valid_reg[k] <= 1'b1;
                    slot_reg[k]      <= add_result;
                end else if (rsp_hs[k]) begin
                    rsp_valid_reg[k] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign err       = err_reg;
    assign idle      = ~blanking & ~(|busy_reg) & ~(|tag_valid_reg) & ~(|rsp_valid_reg);
endmodule

// File: tb/tb_posit_add_arbiter_es3.sv
// Directed bench for posit_add_arbiter_es3: blanking, latency, round-robin order,
// backpressure, mid-flight reset and error injection, with hand-computed sums.

module tb_posit_add_arbiter_es3;
    import posit_es3_pkg::*;

    localparam int N  = 4;
    localparam int W  = POSIT_SERIALIZED_WIDTH_ES3;
    localparam int WS = POSIT_SERIALIZED_WIDTH_SUM_ES3;

    // Operands: {sign, zero, inf, scale[8:0], frac[9:0]}
    localparam logic [W-1:0] P_ONE     = {3'b000, 9'd0,    10'd0};
    localparam logic [W-1:0] P_TWO     = {3'b000, 9'd1,    10'd0};
    localparam logic [W-1:0] P_MONE    = {3'b100, 9'd0,    10'd0};
    localparam logic [W-1:0] P_ONEHALF = {3'b000, 9'd0,    10'h200};
    localparam logic [W-1:0] P_TINY    = {3'b000, 9'h1EC,  10'd0};
    localparam logic [W-1:0] P_ZERO    = {3'b010, 9'd0,    10'd0};
    // Sums: {sign, zero, inf, scale[8:0], frac[13:0] with hidden bit at MSB}
    localparam logic [WS-1:0] S_TWO     = {3'b000, 9'd1, 14'h2000};
    localparam logic [WS-1:0] S_THREE   = {3'b000, 9'd1, 14'h3000};
    localparam logic [WS-1:0] S_ONE     = {3'b000, 9'd0, 14'h2000};
    localparam logic [WS-1:0] S_MTWO    = {3'b100, 9'd1, 14'h2000};
    localparam logic [WS-1:0] S_ONE_STK = {3'b000, 9'd0, 14'h2001};
    localparam logic [WS-1:0] S_ONEHALF = {3'b000, 9'd0, 14'h3000};
    localparam logic [WS-1:0] S_ZERO    = {3'b010, 9'd0, 14'h0000};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_in1 = '0;
    logic [N*W-1:0]  req_in2 = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [N*WS-1:0] rsp_result;
    logic            idle;
    logic            err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0]    exp_gnt [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0]    exp_rv  [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                    4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
    logic [WS-1:0] exp_cont [4] = '{S_THREE, S_ONE, S_MTWO, S_ONE_STK};
    logic [W-1:0]  dir_a   [5]  = '{P_ONEHALF, P_ZERO,    P_ONE,  P_TWO,   P_MONE};
    logic [W-1:0]  dir_b   [5]  = '{P_ONEHALF, P_ONEHALF, P_MONE, P_ONE,   P_TWO};
    logic [WS-1:0] dir_s   [5]  = '{S_THREE,   S_ONEHALF, S_ZERO, S_THREE, S_ONE};

    posit_add_arbiter_es3 #(.N_REQ(N), .LAT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .idle       (idle),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        req_in1[r*W +: W] = a;
        req_in2[r*W +: W] = b;
    endtask

    // Called right after the handshake edge: checks latency and result, then consumes.
    task automatic wait_rsp(input int r, input logic [WS-1:0] exp, input string tag);
        int n;
        n = 1;
        while (!rsp_valid[r] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_res"}, 64'(rsp_result[r*WS +: WS]), 64'(exp));
        rsp_ready[r] = 1'b1;
        tick();
        rsp_ready[r] = 1'b0;
        check({tag, "_consumed"}, 64'(rsp_valid[r]), 64'd0);
    endtask

    task automatic do_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [WS-1:0] exp, input string tag);
        int n;
        set_ops(r, a, b);
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_hs"}, 64'(req_ready[r]), 64'd1);
        tick();
        req_valid[r] = 1'b0;
        wait_rsp(r, exp, tag);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!idle && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(idle), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g0;
        int gcnt;

        // Post-reset blanking with a spurious done held high
        set_ops(0, P_ONE, P_ONE);
        req_valid = 4'b0001;
        force dut.add_done = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result_zero", 64'(rsp_result == '0), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_idle", 64'(idle), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("blank_ready_c%0d", c), 64'(req_ready), 64'd0);
            if (c == 3)
                release dut.add_done;
            tick();
        end
        #1;
        check("blank_first_grant", 64'(req_ready), 64'b0001);
        check("blank_err", 64'(err), 64'd0);
        tick();
        req_valid = '0;
        wait_rsp(0, S_TWO, "blank_op");
        check("blank_err_after", 64'(err), 64'd0);

        // Single op on requester 2, then a directed set on requester 3
        wait_idle("pre_single_idle");
        do_op(2, P_ONE, P_ONE, S_TWO, "single");
        check("single_idle", 64'(idle), 64'd1);
        for (int i = 0; i < 5; i++)
            do_op(3, dir_a[i], dir_b[i], dir_s[i], $sformatf("dir%0d", i));

        // Full contention from rr_ptr = 0
        do_reset();
        set_ops(0, P_ONE, P_TWO);
        set_ops(1, P_TWO, P_MONE);
        set_ops(2, P_MONE, P_MONE);
        set_ops(3, P_ONE, P_TINY);
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("cont_grant_c%0d", c), 64'(req_ready), 64'(exp_gnt[c]));
            check($sformatf("cont_rspv_c%0d", c), 64'(rsp_valid), 64'(exp_rv[c]));
            if (c >= 5 && c <= 8)
                check($sformatf("cont_res_r%0d", c - 5),
                      64'(rsp_result[(c-5)*WS +: WS]), 64'(exp_cont[c-5]));
            tick();
        end
        req_valid = '0;
        wait_idle("cont_drain_idle");

        // Backpressure on requester 1 while requester 0 keeps issuing
        rsp_ready = 4'b1101;
        set_ops(1, P_TWO, P_MONE);
        set_ops(0, P_ONEHALF, P_ONEHALF);
        req_valid = 4'b0010;
        #1;
        check("bp_first_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0011;
        g0 = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (req_ready[0])
                g0++;
            check($sformatf("bp_ready1_k%0d", k), 64'(req_ready[1]), 64'd0);
            if (k >= 5) begin
                check($sformatf("bp_rspv1_k%0d", k), 64'(rsp_valid[1]), 64'd1);
                check($sformatf("bp_res1_k%0d", k), 64'(rsp_result[1*WS +: WS]), 64'(S_ONE));
            end
            if (rsp_valid[0])
                check($sformatf("bp_res0_k%0d", k), 64'(rsp_result[0*WS +: WS]), 64'(S_THREE));
            tick();
        end
        check("bp_grants_r0", 64'(g0), 64'd4);
        req_valid = 4'b0010;
        rsp_ready = 4'b1111;
        #1;
        check("bp_release_same_cycle", 64'(req_ready[1]), 64'd0);
        tick();
        #1;
        check("bp_regrant", 64'(req_ready[1]), 64'd1);
        tick();
        req_valid = '0;
        wait_idle("bp_drain_idle");

        // Reset while three operations are in flight
        rsp_ready = '0;
        set_ops(0, P_ONE, P_ONE);
        set_ops(1, P_ONE, P_TWO);
        set_ops(2, P_MONE, P_MONE);
        req_valid = 4'b0111;
        gcnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            gcnt += $countones(req_ready);
            tick();
        end
        req_valid = '0;
        check("mid_grants", 64'(gcnt), 64'd3);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rspv", 64'(rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("mid_rspv_c%0d", c), 64'(rsp_valid), 64'd0);
            check($sformatf("mid_err_c%0d", c), 64'(err), 64'd0);
            tick();
        end
        check("mid_idle", 64'(idle), 64'd1);
        check("mid_result_zero", 64'(rsp_result == '0), 64'd1);

        // Error injection: done with no tag outside blanking
        #1;
        check("inj_err_before", 64'(err), 64'd0);
        force dut.add_done = 1'b1;
        tick();
        release dut.add_done;
        #1;
        check("inj_err_set", 64'(err), 64'd1);
        check("inj_rspv", 64'(rsp_valid), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("inj_err_sticky_c%0d", c), 64'(err), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        check("inj_err_cleared", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/posit_add_arbiter_es3.md
# posit_add_arbiter_es3

Round-robin arbiter that shares one internal `positadd_4_raw_es3` pipeline (ES=3, 4-cycle latency) among `N_REQ` requesters, using valid/ready request and response channels. Each requester has at most one operation in flight and a dedicated result holding register. A tag shift register tracks in-flight operations to route each adder result back to its requester. The block sits between the posit accumulation engines and the shared adder datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LAT`, 4: adder start-to-done latency in cycles. Must match the instantiated adder.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: request valid, one bit per requester.
- `req_ready` output N_REQ: request accepted. A handshake occurs in any cycle where valid and ready are both high.
- `req_in1` input N_REQ*POSIT_SERIALIZED_WIDTH_ES3: operand A per requester. Slice i belongs to requester i.
- `req_in2` input N_REQ*POSIT_SERIALIZED_WIDTH_ES3: operand B per requester.
- `rsp_valid` output N_REQ: result slot i holds a result.
- `rsp_ready` input N_REQ: requester consumes its result.
- `rsp_result` output N_REQ*POSIT_SERIALIZED_WIDTH_SUM_ES3: raw serialized sum per requester, as produced by the adder.
- `idle` output 1: high when there are no in-flight operations, no occupied slots and no blanking.
- `err` output 1: sticky tag/done mismatch flag. Cleared only by reset.

## Operation
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `err`=0, `idle`=0. Reset also clears `busy[]`, the tag pipe and `rr_ptr`, and loads `blank_cnt`=LAT.
- **Blanking:** the adder has no reset, so the block ignores the adder for LAT cycles after reset.
  - While `blank_cnt`≠0: decrement each cycle, no grants, adder `done` ignored.
  - `idle` goes high once `blank_cnt`=0 and nothing else is pending.
- **Eligibility:** requester i is eligible when `req_valid[i] & ~busy[i] & (blank_cnt==0)`.
- **Grant:** at most one grant per cycle, the first eligible index searching from `rr_ptr` upward modulo N_REQ.
  - `req_ready[i]`=1 only for the granted index. It is combinational from registered state and `req_valid`.
- **Issue:** on a handshake for requester i in cycle t:
  - Drive adder `start`=1 with `in1`/`in2` taken from slice i.
  - Set `busy[i]` and push tag {1, i} into stage 0 of the LAT-deep tag pipe.
  - `rr_ptr` ← (i+1) mod N_REQ.
  - With no handshake: `start`=0, push tag {0, x}, `rr_ptr` unchanged.
- **Retire:** in cycle t+LAT the adder `done`=1 and the tag pipe output valid=1.
  - Capture `result` into slot[idx]; `rsp_valid[idx]` ← 1.
  - If `done` ≠ tag valid while not blanking, set `err`=1 and drop the result.
- **Response:** on `rsp_valid[i] & rsp_ready[i]`, clear `rsp_valid[i]` and `busy[i]` at that edge. Requester i becomes eligible in the next cycle.
- **Slot ownership:** `busy[i]` spans issue through consumption, so no slot is ever overwritten. `rsp_result[i]` holds stable while `rsp_valid[i]`=1.
- **Simultaneous events:** a retire to slot j and a response handshake on slot k≠j in the same cycle are both performed. Retire and handshake cannot hit the same slot in one cycle (guaranteed by `busy`).
- **Reset mid-operation:** all tags are dropped and no stale result is ever delivered. The blanking window covers the adder drain.
- Arithmetic and sign handling are entirely the adder's. The block never modifies operand or result bits.

## Timing
- Request-handshake to `rsp_valid` latency is LAT+1 = 5 cycles: handshake in cycle t, `rsp_valid` high from cycle t+5.
- Peak throughput is 1 issue/cycle across requesters and 1 per (LAT+2) cycles per requester when `rsp_ready` is tied high.
- Round-robin fairness: a continuously eligible requester is granted within N_REQ cycles.
- `err` rises in the cycle after the mismatching `done`.
- First grant possible in cycle LAT after `rst_n` deasserts.

## Test plan
- **Post-reset blanking:** release `rst_n` with `req_valid`=4'b0001 held. Require `req_ready`=0 for cycles 0..3, grant in cycle 4, and `err`=0 even if the adder `done` is X/1 during blanking.
- **Single op:** requester 2 adds 1.0+1.0 (serialized scale 0, zero=0). Require `rsp_valid[2]` exactly 5 cycles after the handshake, `rsp_result[2]` scale=1 with fraction MSB set, and `idle`=1 after `rsp_ready[2]`.
- **Full contention:** all 4 `req_valid` high, `rsp_ready` tied 1, `rr_ptr`=0. Require grant order 0,1,2,3,0,… with one grant per cycle. Requester 0 is regranted no earlier than 6 cycles after its first grant. Each result matches the software posit model.
- **Backpressure:** hold `rsp_ready[1]`=0 for 20 cycles. Require `rsp_result[1]` stable, `req_ready[1]`=0 throughout, and other requesters still served. After release, requester 1 is regranted the next cycle.
- **Reset mid-flight:** issue 3 ops, then assert `rst_n`=0 for 1 cycle 2 cycles later. Require all `rsp_valid`=0, no stale result delivered, and `err`=0 after recovery.
- **Error injection:** force adder `done`=1 in a cycle with tag valid=0 (not blanking). Require `err`=1 the next cycle, sticky until reset, with no `rsp_valid` change.
